// File: rtl/ru_pkg.sv
// Shared definitions for the reduction-unit pair issuer: data width, pad
// element, mode bit positions and the issuer state encoding.
package ru_pkg;

    localparam int           DATA_W        = 16;
    // Most negative Q value: its exp() contributes ~0 to the softmax sum.
    localparam logic [15:0]  PAD_VAL       = 16'h8000;

    localparam int           MODE_MULT_BIT = 0;
    localparam int           MODE_MUX_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } issue_state_t;

endpackage

// File: rtl/ru_pair_issuer.sv
// Pair issuer ahead of the softmax reduction unit. Takes one signed element
// per cycle, groups consecutive elements into (in0, in1) pairs, pads an odd
// tail with PAD_VAL and pulses o_done with the last pair of each vector.
// i_en freezes every register so the frozen reduction unit sees each pulse once.
// Optional: define RU_ISSUE_MAX_TRACK_EN to add the running-max output o_max.
module ru_pair_issuer
    import ru_pkg::*;
#(
    parameter int                DATA_W  = ru_pkg::DATA_W,
    parameter int                LEN_W   = 8,
    parameter logic [DATA_W-1:0] PAD_VAL = ru_pkg::PAD_VAL
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_mode,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ru_valid,
    output logic [DATA_W-1:0] o_ru_in0,
    output logic [DATA_W-1:0] o_ru_in1,
    output logic              o_ru_sel_mult,
    output logic              o_ru_sel_mux,
    output logic              o_busy,
    output logic              o_done
`ifdef RU_ISSUE_MAX_TRACK_EN
    ,
    output logic [DATA_W-1:0] o_max
`endif
);

    issue_state_t      state_q;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] held_q;
    logic [DATA_W-1:0] in0_q, in1_q;
    logic              vld_q, done_q, busy_q, mult_q, mux_q;
    logic              last;

    // Ready only while a vector is being collected and the pipe is not stalled.
    assign o_ready = i_en && (state_q != IDLE);
    assign cnt_d   = cnt_q + 1'b1;
    assign last    = (cnt_d == len_q);

    // FSM, element counter, pair registers and pulse outputs; all frozen when i_en is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            held_q  <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            mult_q  <= 1'b0;
            mux_q   <= 1'b0;
        end else if (i_en) begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        len_q  <= i_len;
                        mult_q <= i_mode[MODE_MULT_BIT];
                        mux_q  <= i_mode[MODE_MUX_BIT];
                        cnt_q  <= '0;
                        if (i_len != '0) begin
                            state_q <= FIRST;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FIRST: begin
                    if (i_valid) begin
                        held_q <= i_data;
                        cnt_q  <= cnt_d;
                        if (last) begin
                            // Odd tail: issue the lone element against the pad.
                            in0_q   <= i_data;
                            in1_q   <= PAD_VAL;
                            vld_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= SECOND;
                        end
                    end
                end
                SECOND: begin
                    if (i_valid) begin
                        in0_q <= held_q;
                        in1_q <= i_data;
                        vld_q <= 1'b1;
                        cnt_q <= cnt_d;
                        if (last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= FIRST;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ru_valid    = vld_q;
    assign o_ru_in0      = in0_q;
    assign o_ru_in1      = in1_q;
    assign o_ru_sel_mult = mult_q;
    assign o_ru_sel_mux  = mux_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

`ifdef RU_ISSUE_MAX_TRACK_EN
    logic [DATA_W-1:0] max_q;

    // Running signed max of accepted elements; the pad never enters the compare.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            max_q <= PAD_VAL;
        end else if (i_en) begin
            if (state_q == IDLE) begin
                if (i_start) max_q <= PAD_VAL;
            end else if (i_valid && ($signed(i_data) > $signed(max_q))) begin
                max_q <= i_data;
            end
        end
    end

    assign o_max = max_q;
`endif

endmodule

// File: tb/tb_ru_pair_issuer.sv
// Self-checking bench for ru_pair_issuer: directed scenarios plus randomized
// vectors with random valid gaps, stalls and stray starts, checked every cycle
// against a vector-level reference model (element index within the vector,
// held element, pair/done expectations).
module tb_ru_pair_issuer;

    localparam logic [15:0] PAD = 16'h8000;

    logic        i_clk = 1'b0;
    logic        i_rst, i_en, i_start, i_valid;
    logic [7:0]  i_len;
    logic [1:0]  i_mode;
    logic [15:0] i_data;
    logic        o_ready, o_ru_valid, o_ru_sel_mult, o_ru_sel_mux, o_busy, o_done;
    logic [15:0] o_ru_in0, o_ru_in1;
`ifdef RU_ISSUE_MAX_TRACK_EN
    logic [15:0] o_max;
`endif

    ru_pair_issuer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_start(i_start),
        .i_len(i_len), .i_mode(i_mode), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_ru_valid(o_ru_valid), .o_ru_in0(o_ru_in0),
        .o_ru_in1(o_ru_in1), .o_ru_sel_mult(o_ru_sel_mult),
        .o_ru_sel_mux(o_ru_sel_mux), .o_busy(o_busy), .o_done(o_done)
`ifdef RU_ISSUE_MAX_TRACK_EN
        , .o_max(o_max)
`endif
    );

    always #5 i_clk = ~i_clk;

    int vec = 0;
    int mis = 0;

    // Reference model: a vector is "open" while fewer than len elements were taken.
    bit          m_act;
    int          m_len, m_idx;
    logic [1:0]  m_mode;
    logic [15:0] m_held, m_in0, m_in1, m_max;
    bit          m_vld, m_done;
    logic [15:0] fq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_open();
        return m_act && (m_idx < m_len);
    endfunction

    function automatic void m_reset();
        m_act = 0; m_len = 0; m_idx = 0; m_mode = 2'b00;
        m_held = '0; m_in0 = '0; m_in1 = '0; m_max = PAD;
        m_vld = 0; m_done = 0;
    endfunction

    // One clock: inputs already driven; check ready, step model, check outputs.
    task automatic cyc();
        #1;
        chk("ready", o_ready, i_en && m_open());
        if (i_rst) begin
            m_reset();
        end else if (i_en) begin
            m_vld = 0; m_done = 0;
            if (!m_open()) begin
                if (i_start) begin
                    m_act = 1; m_len = i_len; m_idx = 0; m_mode = i_mode; m_max = PAD;
                    if (i_len == 0) m_done = 1;
                end
            end else if (i_valid) begin
                m_idx++;
                if ($signed(i_data) > $signed(m_max)) m_max = i_data;
                if (m_idx % 2 == 1) begin
                    m_held = i_data;
                    if (m_idx == m_len) begin
                        m_in0 = i_data; m_in1 = PAD; m_vld = 1; m_done = 1;
                    end
                end else begin
                    m_in0 = m_held; m_in1 = i_data; m_vld = 1;
                    if (m_idx == m_len) m_done = 1;
                end
            end
        end
        @(posedge i_clk);
        #1;
        chk("ru_valid", o_ru_valid, m_vld);
        chk("done", o_done, m_done);
        chk("busy", o_busy, m_open());
        chk("sel_mult", o_ru_sel_mult, m_mode[0]);
        chk("sel_mux", o_ru_sel_mux, m_mode[1]);
        chk("in0", o_ru_in0, m_in0);
        chk("in1", o_ru_in1, m_in1);
`ifdef RU_ISSUE_MAX_TRACK_EN
        chk("max", o_max, m_max);
`endif
    endtask

    task automatic start_vec(input int len, input logic [1:0] mode);
        i_start = 1; i_len = len[7:0]; i_mode = mode; i_en = 1; i_valid = 0;
        cyc();
        i_start = 0;
    endtask

    // Feed fq back to back with i_en high, then one idle cycle.
    task automatic vec_fixed(input logic [1:0] mode);
        start_vec(fq.size(), mode);
        foreach (fq[k]) begin
            i_valid = 1; i_data = fq[k];
            cyc();
        end
        i_valid = 0;
        cyc();
    endtask

    // Random vector with valid gaps, stalls and stray starts while open.
    task automatic vec_rand(input int len, input int pv, input int pe);
        int budget;
        start_vec(len, 2'($urandom));
        budget = 0;
        while (m_open() && budget < 2000) begin
            i_valid = ($urandom_range(99) < pv);
            i_data  = 16'($urandom);
            i_en    = ($urandom_range(99) < pe);
            i_start = ($urandom_range(7) == 0);
            i_len   = 8'($urandom);
            i_mode  = 2'($urandom);
            cyc();
            budget++;
        end
        i_start = 0;
        if (budget >= 2000) chk("timeout", 1, 0);
    endtask

    initial begin
        m_reset();
        i_rst = 1; i_en = 0; i_start = 0; i_len = '0; i_mode = '0;
        i_valid = 0; i_data = '0;
        cyc();
        i_en = 1;
        cyc();
        i_rst = 0;
        chk("rst_valid", o_ru_valid, 0);
        chk("rst_busy", o_busy, 0);

        // Even-length vector with mixed signs.
        fq = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
        vec_fixed(2'b00);
        chk("t1_in0", o_ru_in0, 16'hFF00);
        chk("t1_in1", o_ru_in1, 16'h0080);
`ifdef RU_ISSUE_MAX_TRACK_EN
        chk("t1_max", o_max, 16'h0200);
`endif

        // Odd length: tail padded.
        fq = '{16'h0010, 16'h0020, 16'h0030};
        vec_fixed(2'b11);
        chk("t2_in1_pad", o_ru_in1, PAD);

        // Zero length: done only.
        start_vec(0, 2'b00);
        chk("t3_done", o_done, 1);
        chk("t3_valid", o_ru_valid, 0);
        i_valid = 0;
        cyc();

        // Stall right after the final accept of a length-2 vector.
        start_vec(2, 2'b00);
        i_valid = 1; i_data = 16'h1234; cyc();
        i_data = 16'h5678; cyc();
        i_valid = 0; i_en = 0;
        repeat (3) begin
            cyc();
            chk("t4_hold_valid", o_ru_valid, 1);
        end
        i_en = 1; cyc();
        chk("t4_drop", o_ru_valid, 0);

        // Stray start with another mode while busy.
        start_vec(2, 2'b01);
        i_valid = 1; i_data = 16'h0001; i_start = 1; i_mode = 2'b10; cyc();
        i_start = 0; i_data = 16'h0002; cyc();
        chk("t5_mult", o_ru_sel_mult, 1);
        chk("t5_mux", o_ru_sel_mux, 0);
        i_valid = 0; cyc();

        // Reset mid-vector, then a clean length-2 vector.
        start_vec(4, 2'b11);
        i_valid = 1; i_data = 16'h7777; cyc();
        i_valid = 0; i_rst = 1; cyc();
        i_rst = 0;
        chk("t6_rst_in0", o_ru_in0, 0);
        fq = '{16'h0A0A, 16'h0B0B};
        vec_fixed(2'b00);

        // Randomized vectors, including back-to-back starts on the done cycle.
        for (int n = 0; n < 60; n++) begin
            vec_rand($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 17),
                     $urandom_range(40, 100), $urandom_range(50, 100));
        end
        i_en = 1; i_valid = 0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
